// File: rtl/xnor_match_pkg.sv
// Shared types and helpers for the xnor_match_unit serial pattern correlator.
package xnor_match_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
  } state_t;

  // A threshold above the window length can never be reached, so it saturates at WIDTH.
  function automatic int unsigned clamp_thresh(input int unsigned thresh,
                                               input int unsigned width);
    return (thresh > width) ? width : thresh;
  endfunction

endpackage

// File: rtl/xnor_match_unit_popcount.sv
// Combinational agreement counter: popcount of the bitwise XNOR of two equal-width words.
module xnor_popcount #(
  parameter int WIDTH = 8,
  parameter int SW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [SW-1:0]    count
);

  logic [WIDTH-1:0] w_agree;

  assign w_agree = ~(a ^ b);

  // NOTE: count gets a value before the loop, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + SW'(w_agree[i]);
    end
  end

endmodule

// File: rtl/xnor_match_unit.sv
// Serial pattern correlator: shifts qualified bits into a window, scores it against a
// programmable pattern, flags threshold matches and keeps a saturating match count.
module xnor_match_unit
  import xnor_match_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  parameter int SW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pat_load,
  input  logic [WIDTH-1:0] pat_in,
  input  logic [SW-1:0]    thresh_in,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             clr_cnt,
  output logic             match,
  output logic [SW-1:0]    score,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic             armed
);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_pattern;
  logic [WIDTH-1:0] r_window;
  logic [WIDTH-1:0] w_window_next;
  logic [SW-1:0]    r_thresh;
  logic [SW-1:0]    r_fill;
  logic [SW-1:0]    r_score;
  logic [SW-1:0]    w_score;
  logic             r_match;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_sat;
  logic             w_accept;
  logic             w_fill_last;
  logic             w_eval;
  logic             w_match_next;

  // A pattern load owns the cycle: any bit offered alongside it is dropped.
  assign w_accept      = bit_valid && !pat_load && (r_state != IDLE);
  assign w_fill_last   = (r_fill == SW'(WIDTH - 1));
  assign w_eval        = w_accept && ((r_state == RUN) || w_fill_last);
  assign w_window_next = {r_window[WIDTH-2:0], bit_in};
  assign w_match_next  = w_eval && (w_score >= r_thresh);

  xnor_popcount #(
    .WIDTH(WIDTH),
    .SW   (SW)
  ) u_popcount (
    .a    (w_window_next),
    .b    (r_pattern),
    .count(w_score)
  );

  always_comb begin
    w_state_next = r_state;
    if (pat_load) begin
      w_state_next = FILL;
    end else if ((r_state == FILL) && w_accept && w_fill_last) begin
      w_state_next = RUN;
    end
  end

  // A clear coinciding with a match keeps that match, so the count restarts at one.
  always_comb begin
    w_cnt_next = r_cnt;
    if (clr_cnt) begin
      w_cnt_next = w_match_next ? CNT_W'(1) : '0;
    end else if (w_match_next && !(&r_cnt)) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pattern <= '0;
      r_thresh  <= SW'(WIDTH);
      r_window  <= '0;
      r_fill    <= '0;
      r_match   <= 1'b0;
      r_score   <= '0;
      r_cnt     <= '0;
      r_sat     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_match <= w_match_next;
      r_cnt   <= w_cnt_next;
      r_sat   <= &w_cnt_next;
      if (w_eval) begin
        r_score <= w_score;
      end
      if (pat_load) begin
        r_pattern <= pat_in;
        r_thresh  <= SW'(clamp_thresh(32'(thresh_in), WIDTH));
        r_window  <= '0;
        r_fill    <= '0;
      end else if (w_accept) begin
        r_window <= w_window_next;
        if (r_state == FILL) begin
          r_fill <= r_fill + SW'(1);
        end
      end
    end
  end

  assign match     = r_match;
  assign score     = r_score;
  assign match_cnt = r_cnt;
  assign cnt_sat   = r_sat;
  assign armed     = (r_state == RUN);

endmodule

// File: tb/tb_xnor_match_unit.sv
// Self-checking bench for xnor_match_unit: hand-derived vector table plus a randomised
// stream checked against a bit-history reference model through a scoreboard queue.
module tb_xnor_match_unit;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;
  localparam int SW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             pat_load;
  logic [WIDTH-1:0] pat_in;
  logic [SW-1:0]    thresh_in;
  logic             bit_valid;
  logic             bit_in;
  logic             clr_cnt;
  logic             match;
  logic [SW-1:0]    score;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;
  logic             armed;

  xnor_match_unit #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pat_load (pat_load),
    .pat_in   (pat_in),
    .thresh_in(thresh_in),
    .bit_valid(bit_valid),
    .bit_in   (bit_in),
    .clr_cnt  (clr_cnt),
    .match    (match),
    .score    (score),
    .match_cnt(match_cnt),
    .cnt_sat  (cnt_sat),
    .armed    (armed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       pl;
    logic [7:0] pat;
    logic [3:0] th;
    logic       bv;
    logic       bi;
    logic       clr;
  } stim_t;

  typedef struct {
    logic       m;
    logic [3:0] sc;
    logic [1:0] cnt;
    logic       sat;
    logic       arm;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: raw bit history instead of a shift register.
  int         m_state;
  bit         m_hist[$];
  logic [7:0] m_pat;
  int         m_th;
  logic [3:0] m_score;
  logic [1:0] m_cnt;
  logic       m_match;

  function automatic stim_t S(logic r, logic pl, logic [7:0] p, logic [3:0] t,
                              logic bv, logic bi, logic c);
    stim_t s;
    s.rst = r; s.pl = pl; s.pat = p; s.th = t; s.bv = bv; s.bi = bi; s.clr = c;
    return s;
  endfunction

  function automatic exp_t E(logic m, logic [3:0] sc, logic [1:0] cnt, logic sat, logic arm);
    exp_t e;
    e.m = m; e.sc = sc; e.cnt = cnt; e.sat = sat; e.arm = arm;
    return e;
  endfunction

  task automatic add(input stim_t s, input exp_t e);
    vec_t v;
    v.s = s;
    v.e = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s step %0d: got %0d want %0d", name, idx, act, req);
    end
  endtask

  task automatic apply(input stim_t s, input exp_t e, input int idx);
    exp_t got;
    rst       = s.rst;
    pat_load  = s.pl;
    pat_in    = s.pat;
    thresh_in = s.th;
    bit_valid = s.bv;
    bit_in    = s.bi;
    clr_cnt   = s.clr;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", idx, 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      check("match", idx, 32'(match), 32'(got.m));
      check("score", idx, 32'(score), 32'(got.sc));
      check("match_cnt", idx, 32'(match_cnt), 32'(got.cnt));
      check("cnt_sat", idx, 32'(cnt_sat), 32'(got.sat));
      check("armed", idx, 32'(armed), 32'(got.arm));
    end
  endtask

  task automatic model_step(input stim_t s, output exp_t e);
    bit ev;
    int agree;
    ev = 1'b0;
    if (s.rst) begin
      m_state = 0;
      m_hist.delete();
      m_pat   = '0;
      m_th    = WIDTH;
      m_score = '0;
      m_cnt   = '0;
      m_match = 1'b0;
    end else begin
      if (s.pl) begin
        m_pat = s.pat;
        m_th  = (int'(s.th) > WIDTH) ? WIDTH : int'(s.th);
        m_hist.delete();
        m_state = 1;
      end else if (s.bv && m_state != 0) begin
        m_hist.push_back(s.bi);
        if (m_hist.size() > WIDTH) void'(m_hist.pop_front());
        if (m_hist.size() == WIDTH) begin
          ev      = 1'b1;
          m_state = 2;
        end
      end
      m_match = 1'b0;
      if (ev) begin
        agree = 0;
        for (int k = 0; k < WIDTH; k++) begin
          if (m_hist[k] == m_pat[WIDTH-1-k]) agree++;
        end
        m_score = 4'(agree);
        m_match = (agree >= m_th);
      end
      if (s.clr) m_cnt = m_match ? 2'd1 : 2'd0;
      else if (m_match && m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
    end
    e = E(m_match, m_score, m_cnt, (m_cnt == 2'd3), (m_state == 2));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] seq;
    stim_t      s;
    exp_t       e;

    rst = 1'b1; pat_load = 1'b0; pat_in = '0; thresh_in = '0;
    bit_valid = 1'b0; bit_in = 1'b0; clr_cnt = 1'b0;

    // Reset, then bits offered in IDLE are ignored.
    add(S(1, 0, 0, 0, 0, 0, 0), E(0, 0, 0, 0, 0));
    add(S(1, 0, 0, 0, 0, 0, 0), E(0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) add(S(0, 0, 0, 0, 1, (i % 2 == 0), 0), E(0, 0, 0, 0, 0));

    // Exact match of 1011_0010 at threshold 8.
    seq = 8'b1011_0010;
    add(S(0, 1, 8'hB2, 4'd8, 0, 0, 0), E(0, 0, 0, 0, 0));
    for (int i = 7; i >= 1; i--) add(S(0, 0, 0, 0, 1, seq[i], 0), E(0, 0, 0, 0, 0));
    add(S(0, 0, 0, 0, 1, seq[0], 0), E(1, 8, 1, 0, 1));
    add(S(0, 0, 0, 0, 0, 0, 0), E(0, 8, 1, 0, 1));

    // Reload from RUN with a discarded bit; threshold 6: two-bit then three-bit mismatch.
    add(S(0, 1, 8'hB2, 4'd6, 1, 1, 1), E(0, 8, 0, 0, 0));
    seq = 8'b1011_0001;
    for (int i = 7; i >= 1; i--) add(S(0, 0, 0, 0, 1, seq[i], 0), E(0, 8, 0, 0, 0));
    add(S(0, 0, 0, 0, 1, seq[0], 0), E(1, 6, 1, 0, 1));
    add(S(0, 0, 0, 0, 1, 0, 0), E(0, 5, 1, 0, 1));

    // Threshold 12 clamps to 8, so an exact window still matches.
    add(S(0, 1, 8'hB2, 4'd12, 0, 0, 0), E(0, 5, 1, 0, 0));
    seq = 8'b1011_0010;
    for (int i = 7; i >= 1; i--) add(S(0, 0, 0, 0, 1, seq[i], 0), E(0, 5, 1, 0, 0));
    add(S(0, 0, 0, 0, 1, seq[0], 0), E(1, 8, 2, 0, 1));
    add(S(0, 0, 0, 0, 1, 0, 0), E(0, 3, 2, 0, 1));

    // Threshold 0: every evaluation matches; 2-bit counter saturates, then clears.
    add(S(0, 1, 8'hB2, 4'd0, 0, 0, 1), E(0, 3, 0, 0, 0));
    for (int i = 0; i < 7; i++) add(S(0, 0, 0, 0, 1, 1, 0), E(0, 3, 0, 0, 0));
    add(S(0, 0, 0, 0, 1, 1, 0), E(1, 4, 1, 0, 1));
    add(S(0, 0, 0, 0, 1, 1, 0), E(1, 4, 2, 0, 1));
    add(S(0, 0, 0, 0, 1, 1, 0), E(1, 4, 3, 1, 1));
    add(S(0, 0, 0, 0, 1, 1, 0), E(1, 4, 3, 1, 1));
    add(S(0, 0, 0, 0, 0, 0, 1), E(0, 4, 0, 0, 1));
    add(S(0, 0, 0, 0, 1, 1, 0), E(1, 4, 1, 0, 1));
    add(S(0, 0, 0, 0, 1, 1, 0), E(1, 4, 2, 0, 1));
    add(S(0, 0, 0, 0, 1, 1, 0), E(1, 4, 3, 1, 1));
    add(S(0, 0, 0, 0, 1, 1, 1), E(1, 4, 1, 0, 1));

    // Reset in FILL after 5 bits, asserted together with pat_load; IDLE ignores bits.
    add(S(0, 1, 8'hB2, 4'd8, 0, 0, 0), E(0, 4, 1, 0, 0));
    for (int i = 0; i < 5; i++) add(S(0, 0, 0, 0, 1, 1, 0), E(0, 4, 1, 0, 0));
    add(S(1, 1, 8'hB2, 4'd8, 1, 1, 0), E(0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) add(S(0, 0, 0, 0, 1, 0, 0), E(0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i].s, vecs[i].e, i);

    // Randomised stream against the reference model.
    for (int i = 0; i < 600; i++) begin
      s.rst = (i == 0) || ($urandom_range(0, 199) == 0);
      s.pl  = (i == 1) || ($urandom_range(0, 39) == 0);
      s.pat = 8'($urandom);
      s.th  = 4'($urandom_range(0, 12));
      s.bv  = ($urandom_range(0, 3) != 0);
      s.bi  = 1'($urandom);
      s.clr = ($urandom_range(0, 19) == 0);
      model_step(s, e);
      apply(s, e, 1000 + i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
